axi_expand: RTL

- Streaming sample widener, the inverse-direction companion to the team's rounding/narrowing stage.
- Takes signed WIDTH_IN samples, sign-extends them to WIDTH_OUT, applies a per-packet runtime left shift (gain), and saturates on overflow.
- Two-stage registered pipeline with full AXI-stream backpressure.
- Reports per-packet and sticky saturation status.
- Sits at the entry of wide-datapath RFNoC blocks, for example ahead of filters or accumulators.

---
 rtl/axi_expand.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/axi_expand.sv
// Streaming sample widener: sign-extend, per-packet left shift, saturate to WIDTH_OUT.
// Two registered stages with AXI-stream backpressure and saturation status reporting.
//
// state  | meaning
// IDLE   | between packets; next accepted beat latches shift
// IN_PKT | inside a packet; beats use the latched shift_r
module axi_expand #(
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 24,
  parameter int SHIFT_W   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 clear,
  input  logic [WIDTH_IN-1:0]  i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [WIDTH_OUT-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 o_sat,
  output logic [CNT_W-1:0]     o_sat_count,
  output logic                 o_sat_count_stb
);

  localparam int PROD_W = WIDTH_OUT + (2**SHIFT_W) - 1;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [SHIFT_W-1:0]    shift_r, eff_shift;
  logic                  s1_valid, s1_last, s1_ready;
  logic [PROD_W-1:0]     s1_prod, prod_in;
  logic                  in_acc, out_xfer;
  logic [PROD_W-WIDTH_OUT:0] hi_bits;
  logic                  sat_flag, s2_sat;
  logic [WIDTH_OUT-1:0]  sat_data;
  logic [CNT_W-1:0]      sat_run, sat_run_inc;

  assign s1_ready = !o_tvalid || o_tready;
  assign i_tready = reset_n && (!s1_valid || s1_ready);
  assign in_acc   = i_tvalid && i_tready;
  assign out_xfer = o_tvalid && o_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shift_r <= '0;
    end else begin
      state <= state_nxt;
      if (in_acc && state == IDLE) shift_r <= shift;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_acc && !i_tlast) state_nxt = IN_PKT;
      IN_PKT:  if (in_acc && i_tlast)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first beat of a packet uses the live shift input, later beats the latched copy
  always_comb begin
    eff_shift = (state == IDLE) ? shift : shift_r;
  end

  always_comb begin
    prod_in = {{(PROD_W-WIDTH_IN){i_tdata[WIDTH_IN-1]}}, i_tdata} << eff_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_last  <= 1'b0;
    end else if (!s1_valid || s1_ready) begin
      s1_valid <= in_acc;
      if (in_acc) begin
        s1_prod <= prod_in;
        s1_last <= i_tlast;
      end
    end
  end

  // Fits when every bit from the output sign position upward agrees
  always_comb begin
    hi_bits  = s1_prod[PROD_W-1:WIDTH_OUT-1];
    sat_flag = !((&hi_bits) || !(|hi_bits));
    if (!sat_flag)
      sat_data = s1_prod[WIDTH_OUT-1:0];
    else if (s1_prod[PROD_W-1])
      sat_data = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    else
      sat_data = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      s2_sat   <= 1'b0;
    end else if (s1_ready) begin
      o_tvalid <= s1_valid;
      if (s1_valid) begin
        o_tdata <= sat_data;
        o_tlast <= s1_last;
        s2_sat  <= sat_flag;
      end
    end
  end

  always_comb begin
    sat_run_inc = sat_run;
    if (s2_sat && sat_run != {CNT_W{1'b1}}) sat_run_inc = sat_run + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_run         <= '0;
      o_sat_count     <= '0;
      o_sat_count_stb <= 1'b0;
      o_sat           <= 1'b0;
    end else begin
      o_sat_count_stb <= 1'b0;
      if (out_xfer) begin
        if (o_tlast) begin
          o_sat_count     <= sat_run_inc;
          o_sat_count_stb <= 1'b1;
          sat_run         <= '0;
        end else begin
          sat_run <= sat_run_inc;
        end
      end
      // Set takes priority over clear
      if (out_xfer && s2_sat) o_sat <= 1'b1;
      else if (clear)         o_sat <= 1'b0;
    end
  end

endmodule
